// File: rtl/gate_check_pkg.sv
// Shared types and truth-table constants for the gate response checker.
// Truth tables are indexed by {a,b}; bit 0 is the a=0,b=0 response.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // One-hot coverage bit for an {a,b} combination.
    function automatic logic [3:0] combo_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/nor_gate.sv
// Two-input NOR gate used as the device under check.
module nor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a | b);

endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL  = {W{1'b1}};
    localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};

    // Count register: reset/clear to zero, increment unless already saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= ZERO_VAL;
        end else if (clr) begin
            q <= ZERO_VAL;
        end else if (inc && (q != MAX_VAL)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Checks observed {a,b,y} samples of a 2-input gate against a latched truth
// table, tracking coverage, vector/error counts and the first failing input.
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       truth_tbl,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [3:0]       coverage,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [1:0]       first_err_idx
);

    localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_END  = IDLE_W'(TIMEOUT);

    state_t             state_r;
    logic [3:0]         tt_r;
    logic [3:0]         coverage_r;
    logic [IDLE_W-1:0]  idle_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic               timeout_r;
    logic               first_err_vld_r;
    logic [1:0]         first_err_idx_r;

    logic               accept_s;
    logic [1:0]         idx_s;
    logic               mismatch_s;
    logic [3:0]         cov_next_s;
    logic               start_run_s;
    logic               err_zero_next_s;
    logic [CNT_W-1:0]   vec_cnt_s;
    logic [CNT_W-1:0]   err_cnt_s;

    // Accept qualification and per-sample comparison against the latched table.
    always_comb begin
        accept_s        = in_valid & in_ready_r;
        idx_s           = {a, b};
        mismatch_s      = y ^ tt_r[idx_s];
        cov_next_s      = coverage_r | combo_onehot(idx_s);
        start_run_s     = start & ((state_r == IDLE) | (state_r == DONE));
        if (err_cnt_s == {CNT_W{1'b0}}) begin
            err_zero_next_s = ~(accept_s & mismatch_s);
        end else begin
            err_zero_next_s = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_run_s),
        .inc (accept_s),
        .q   (vec_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_run_s),
        .inc (accept_s & mismatch_s),
        .q   (err_cnt_s)
    );

    // Run-control FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            tt_r            <= 4'b0000;
            coverage_r      <= 4'b0000;
            idle_r          <= {IDLE_W{1'b0}};
            in_ready_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            timeout_r       <= 1'b0;
            first_err_vld_r <= 1'b0;
            first_err_idx_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // Results hold in DONE until the next start.
                    if (start) begin
                        state_r         <= RUN;
                        tt_r            <= truth_tbl;
                        coverage_r      <= 4'b0000;
                        idle_r          <= {IDLE_W{1'b0}};
                        in_ready_r      <= 1'b1;
                        busy_r          <= 1'b1;
                        done_r          <= 1'b0;
                        pass_r          <= 1'b0;
                        timeout_r       <= 1'b0;
                        first_err_vld_r <= 1'b0;
                        first_err_idx_r <= 2'b00;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        idle_r     <= {IDLE_W{1'b0}};
                        coverage_r <= cov_next_s;
                        if (mismatch_s && !first_err_vld_r) begin
                            first_err_vld_r <= 1'b1;
                            first_err_idx_r <= idx_s;
                        end
                        if (cov_next_s == 4'b1111) begin
                            state_r    <= DONE;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            pass_r     <= err_zero_next_s;
                        end
                    end else if (idle_r == IDLE_LAST) begin
                        state_r    <= DONE;
                        idle_r     <= IDLE_END;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        pass_r     <= 1'b0;
                        timeout_r  <= 1'b1;
                    end else begin
                        idle_r <= idle_r + IDLE_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    pass_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign timeout       = timeout_r;
    assign coverage      = coverage_r;
    assign vec_cnt       = vec_cnt_s;
    assign err_cnt       = err_cnt_s;
    assign first_err_vld = first_err_vld_r;
    assign first_err_idx = first_err_idx_r;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench: checker observes a NOR gate; a rule-level run model
// predicts every status output after each cycle.
module tb_gate_response_checker;
    import gate_check_pkg::*;

    localparam int TO    = 8;
    localparam int CW    = 8;
    localparam int CMAX  = 255;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, a, b, y, flip, nor_y;
    logic [3:0]    truth_tbl;
    logic          in_ready, busy, done, pass, timeout, first_err_vld;
    logic [3:0]    coverage;
    logic [CW-1:0] vec_cnt, err_cnt;
    logic [1:0]    first_err_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model of a run, kept as plain counts and flags.
    bit         m_run, m_done, m_to, m_fvld;
    int         m_vec, m_err, m_idle;
    logic [3:0] m_cov, m_tt;
    logic [1:0] m_fidx;

    always #5 clk = ~clk;

    nor_gate u_nor (.a(a), .b(b), .y(nor_y));
    assign y = nor_y ^ flip;

    gate_response_checker #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .truth_tbl(truth_tbl),
        .in_valid(in_valid), .a(a), .b(b), .y(y),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .coverage(coverage), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .first_err_vld(first_err_vld),
        .first_err_idx(first_err_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        bit exp_pass;
        exp_pass = m_done && (m_err == 0) && (m_cov == 4'b1111) && !m_to;
        chk({tag, ":in_ready"},  {31'd0, in_ready},      {31'd0, m_run});
        chk({tag, ":busy"},      {31'd0, busy},          {31'd0, m_run});
        chk({tag, ":done"},      {31'd0, done},          {31'd0, m_done});
        chk({tag, ":pass"},      {31'd0, pass},          {31'd0, exp_pass});
        chk({tag, ":timeout"},   {31'd0, timeout},       {31'd0, m_to});
        chk({tag, ":coverage"},  {28'd0, coverage},      {28'd0, m_cov});
        chk({tag, ":vec_cnt"},   {24'd0, vec_cnt},       m_vec);
        chk({tag, ":err_cnt"},   {24'd0, err_cnt},       m_err);
        chk({tag, ":fe_vld"},    {31'd0, first_err_vld}, {31'd0, m_fvld});
        chk({tag, ":fe_idx"},    {30'd0, first_err_idx}, {30'd0, m_fidx});
    endtask

    task automatic model_accept(input logic ma, input logic mb, input logic mflip);
        logic observed;
        observed = ~(ma | mb) ^ mflip;
        if (m_vec < CMAX) m_vec++;
        m_cov[{ma, mb}] = 1'b1;
        m_idle = 0;
        if (observed != m_tt[{ma, mb}]) begin
            if (m_err < CMAX) m_err++;
            if (!m_fvld) begin
                m_fvld = 1'b1;
                m_fidx = {ma, mb};
            end
        end
        if (m_cov == 4'b1111) begin
            m_run  = 1'b0;
            m_done = 1'b1;
        end
    endtask

    task automatic model_idle_tick();
        if (m_run) begin
            m_idle++;
            if (m_idle == TO) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_to   = 1'b1;
            end
        end
    endtask

    task automatic send(input logic sa, input logic sb, input logic sflip, input string tag);
        a = sa; b = sb; flip = sflip; in_valid = 1'b1;
        step();
        in_valid = 1'b0; flip = 1'b0;
        if (m_run) model_accept(sa, sb, sflip);
        check_all(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            step();
            model_idle_tick();
            check_all(tag);
        end
    endtask

    task automatic do_start(input logic with_valid, input logic [3:0] tt, input string tag);
        truth_tbl = tt; start = 1'b1; in_valid = with_valid; a = 1'b0; b = 1'b0;
        step();
        start = 1'b0; in_valid = 1'b0;
        if (!m_run) begin
            m_run = 1'b1; m_done = 1'b0; m_to = 1'b0; m_fvld = 1'b0;
            m_vec = 0; m_err = 0; m_idle = 0; m_cov = 4'b0000; m_fidx = 2'b00;
            m_tt = tt;
        end else if (with_valid) begin
            model_accept(1'b0, 1'b0, 1'b0);
        end else begin
            model_idle_tick();
        end
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_run = 1'b0; m_done = 1'b0; m_to = 1'b0; m_fvld = 1'b0;
        m_vec = 0; m_err = 0; m_idle = 0; m_cov = 4'b0000; m_fidx = 2'b00;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] tt_pick [5];
        tt_pick[0] = TT_NOR; tt_pick[1] = TT_OR; tt_pick[2] = TT_AND;
        tt_pick[3] = TT_NAND; tt_pick[4] = TT_XOR;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0;
        flip = 1'b0; truth_tbl = 4'b0000;
        m_tt = 4'b0000;
        step();
        do_reset("reset");

        // start with in_valid in IDLE: sample is not counted
        do_start(1'b1, TT_NOR, "start_with_valid");
        // clean NOR run, back-to-back
        send(1'b0, 1'b0, 1'b0, "nor_00");
        send(1'b0, 1'b1, 1'b0, "nor_01");
        send(1'b1, 1'b0, 1'b0, "nor_10");
        send(1'b1, 1'b1, 1'b0, "nor_11");
        idle_cycles(2, "done_hold");

        // restart from DONE, wrong response at {1,0}
        do_start(1'b0, TT_NOR, "restart_done");
        send(1'b0, 1'b0, 1'b0, "bad_00");
        send(1'b0, 1'b1, 1'b0, "bad_01");
        send(1'b1, 1'b0, 1'b1, "bad_10");
        send(1'b1, 1'b1, 1'b0, "bad_11");

        // partial coverage, then idle until timeout
        do_start(1'b0, TT_NOR, "to_start");
        send(1'b0, 1'b0, 1'b0, "to_00");
        send(1'b0, 1'b1, 1'b0, "to_01");
        idle_cycles(TO + 2, "to_idle");

        // duplicates are counted but do not advance coverage
        do_start(1'b0, TT_NOR, "dup_start");
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, "dup_00");
        send(1'b0, 1'b1, 1'b0, "dup_01");
        send(1'b1, 1'b0, 1'b0, "dup_10");
        send(1'b1, 1'b1, 1'b0, "dup_11");

        // start ignored while running; reset aborts run
        do_start(1'b0, TT_NOR, "rst_start");
        send(1'b0, 1'b0, 1'b0, "rst_a1");
        do_start(1'b0, TT_AND, "start_in_run");
        send(1'b0, 1'b1, 1'b0, "rst_a2");
        do_reset("mid_run_reset");
        do_start(1'b0, TT_NOR, "fresh_start");
        send(1'b1, 1'b1, 1'b0, "fresh_11");
        idle_cycles(TO, "fresh_to");

        // saturation of both counters
        do_start(1'b0, TT_NOR, "sat_start");
        for (int i = 0; i < 300; i++) send(1'b0, 1'b0, 1'b1, "sat_00");
        send(1'b0, 1'b1, 1'b0, "sat_01");
        send(1'b1, 1'b0, 1'b0, "sat_10");
        send(1'b1, 1'b1, 1'b0, "sat_11");

        // randomized runs with random tables, faults and idle gaps
        for (int r = 0; r < 20; r++) begin
            do_start(1'b0, tt_pick[$urandom_range(0, 4)], "rnd_start");
            for (int k = 0; k < 30 && m_run; k++) begin
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(0, TO + 1), "rnd_idle");
                if (m_run) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 7) == 0), "rnd_send");
            end
            if (m_run) idle_cycles(TO, "rnd_drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 Parameter TIMEOUT, default 64: idle cycles in RUN with no accepted vector before the run aborts.
REQ-002 Parameter CNT_W, default 8: width of the vector and error counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high; one clock, synchronous and active-high.
REQ-005 start  input  1  single-cycle pulse that begins a check run.
REQ-006 truth_tbl  input  4  expected output of the gate under check, indexed by {a,b}; bit0 is a=0,b=0.
REQ-007 in_valid  input  1  the observed sample {a,b,y} is presented.
REQ-008 a, b, y  input  1 each  gate stimulus inputs and the observed gate output.
REQ-009 in_ready  output  1  the checker accepts a sample this cycle.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  run verdict, valid while done=1.
REQ-013 timeout  output  1  the run ended by idle timeout.
REQ-014 coverage  output  4  one-hot accumulation of the {a,b} combinations seen.
REQ-015 vec_cnt, err_cnt  output  CNT_W each  accepted vectors and mismatches.
REQ-016 first_err_vld  output  1  at least one mismatch has been recorded.
REQ-017 first_err_idx  output  2  {a,b} of the first mismatch.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE, with all outputs driven from registers.
REQ-019 IDLE->RUN on start=1:
  - truth_tbl is latched into an internal register.
  - coverage, vec_cnt, err_cnt, timeout, first_err_vld and the idle counter are all cleared.
REQ-020 in_ready SHALL equal (state==RUN); a sample is accepted only when in_valid and in_ready are both 1.
REQ-021 On each accept, in one cycle:
  - vec_cnt increments.
  - coverage[{a,b}] is set.
  - If y differs from the latched table bit at {a,b}, err_cnt increments.
  - On the first mismatch only, first_err_idx is captured and first_err_vld is set.
REQ-022 vec_cnt and err_cnt SHALL saturate at all-ones and never wrap.
REQ-023 RUN->DONE on the cycle after an accept that completes coverage (coverage becomes 4'b1111); the completing vector is fully counted.
REQ-024 Idle counter:
  - Increments on each RUN cycle without an accept.
  - Clears on each accept.
  - On reaching TIMEOUT, the FSM goes to DONE and timeout is set to 1.
REQ-025 pass = (err_cnt==0) and (coverage==4'b1111) and not timeout.
  - It is updated on entry to DONE.
  - It reads 0 outside DONE.
REQ-026 start is ignored in RUN.
  - In DONE, start re-enters RUN with the same clearing as REQ-019.
  - Results hold in DONE until then.
REQ-027 In IDLE or DONE, in_valid is ignored; a start arriving together with in_valid does not accept that sample.
REQ-028 Duplicate vectors in RUN SHALL be counted and checked but do not change coverage.

Reset
REQ-029 rst=1 at a clock edge SHALL force:
  - state IDLE.
  - all outputs 0: in_ready, busy, done, pass, timeout, coverage, vec_cnt, err_cnt, first_err_vld, first_err_idx.
  - the latched table and the idle counter to 0.
REQ-030 rst SHALL take priority over start and in_valid in the same cycle; a rst during RUN aborts the run with no verdict.

Structure
REQ-031 A shared package gate_check_pkg SHALL hold:
  - the state enum (IDLE, RUN, DONE).
  - the constants TT_NOR=4'b0001, TT_OR=4'b1110, TT_AND=4'b1000, TT_NAND=4'b0111, TT_XOR=4'b0110.
REQ-032 A single sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) SHALL implement both saturating counters; the idle timer is inline.

Verification
REQ-033 The bench SHALL instantiate the checker against a nor_gate and cover the following scenarios:
  - Start with TT_NOR, then feed 00,01,10,11 with in_valid=1 back-to-back:
    - done rises 1 cycle after the 4th accept.
    - pass=1, vec_cnt=4, err_cnt=0, coverage=1111.
  - Feed the same vectors with y forced wrong at {1,0}:
    - pass=0, err_cnt=1, first_err_vld=1, first_err_idx=2'b10.
  - TIMEOUT=8; feed only 00 and 01, then idle:
    - done and timeout rise after 8 idle cycles.
    - pass=0, coverage=0011.
  - Feed 00 three times, then 01,10,11:
    - vec_cnt=6, coverage=1111.
    - done only after the 6th accept.
  - Assert rst mid-RUN after 2 accepts:
    - next cycle all outputs are 0 and the state is IDLE.
    - a later start yields a fresh run with vec_cnt counting from 0.
  - Assert start together with in_valid in IDLE:
    - that sample is not counted (vec_cnt=0 the next cycle).
    - assert start again in DONE: counters clear and busy=1.
